// File: rtl/program_loader_if.sv
// Host byte stream and instruction-memory write port of program_loader.
// The loader attaches through the slave modport; the host/CPU side uses master.
interface program_loader_if;
  logic        byte_valid_i;
  logic [7:0]  byte_i;
  logic        byte_ready_o;
  logic        program_mem_write_en_o;
  logic [15:0] instruction_o;
  logic [31:0] instruction_addr_o;
  logic        cpu_reset_o;
  logic        done_o;
  logic        error_o;
  logic [15:0] loaded_count_o;

  modport slave (
    input  byte_valid_i, byte_i,
    output byte_ready_o, program_mem_write_en_o, instruction_o, instruction_addr_o,
    output cpu_reset_o, done_o, error_o, loaded_count_o
  );

  modport master (
    output byte_valid_i, byte_i,
    input  byte_ready_o, program_mem_write_en_o, instruction_o, instruction_addr_o,
    input  cpu_reset_o, done_o, error_o, loaded_count_o
  );
endinterface

// File: rtl/program_loader.sv
// Boot loader: length-prefixed little-endian Thumb image -> arm_cpu program memory.
// Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module program_loader #(
  parameter logic [31:0] BASE_ADDR      = 32'd0,
  parameter int unsigned MAX_HALF_WORDS = 1024
) (
  input  logic           clk_i,
  input  logic           reset_i,
  program_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_INSTR_LO,
    S_INSTR_HI,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE,
    S_ERROR
  } state_e;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam state_e S_END = S_CHECK;
`else
  localparam state_e S_END = S_DONE;
`endif

  state_e      state_q, state_d;
  logic [7:0]  len_lo_q, len_lo_d;
  logic [15:0] len_q, len_d;
  logic [7:0]  lo_byte_q, lo_byte_d;
  logic [15:0] count_q, count_d;
  logic [15:0] instr_q, instr_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic        cpu_reset_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic        byte_ready;
  logic        accept;
  logic [15:0] len_full;
  logic [15:0] count_inc;

  assign byte_ready = (state_q != S_DONE) && (state_q != S_ERROR);
  assign accept     = bus.byte_valid_i && byte_ready;
  assign len_full   = {bus.byte_i, len_lo_q};
  assign count_inc  = count_q + 16'd1;

  always_comb begin
    state_d   = state_q;
    len_lo_d  = len_lo_q;
    len_d     = len_q;
    lo_byte_d = lo_byte_q;
    count_d   = count_q;
    instr_d   = instr_q;
    addr_d    = addr_q;
    we_d      = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    csum_d    = accept ? (csum_q ^ bus.byte_i) : csum_q;
`endif
    case (state_q)
      S_LEN_LO: if (accept) begin
        len_lo_d = bus.byte_i;
        state_d  = S_LEN_HI;
      end
      S_LEN_HI: if (accept) begin
        len_d = len_full;
        if (32'(len_full) > MAX_HALF_WORDS) state_d = S_ERROR;
        else if (len_full == 16'd0)         state_d = S_END;
        else                                state_d = S_INSTR_LO;
      end
      S_INSTR_LO: if (accept) begin
        lo_byte_d = bus.byte_i;
        state_d   = S_INSTR_HI;
      end
      S_INSTR_HI: if (accept) begin
        // Write k lands at BASE_ADDR + 2k; the 32-bit add wraps on its own.
        instr_d = {bus.byte_i, lo_byte_q};
        addr_d  = BASE_ADDR + {15'd0, count_q, 1'b0};
        we_d    = 1'b1;
        count_d = count_inc;
        state_d = (count_inc == len_q) ? S_END : S_INSTR_LO;
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CHECK: if (accept) begin
        state_d = (bus.byte_i == csum_q) ? S_DONE : S_ERROR;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_LEN_LO;
      len_lo_q    <= 8'd0;
      len_q       <= 16'd0;
      lo_byte_q   <= 8'd0;
      count_q     <= 16'd0;
      instr_q     <= 16'd0;
      addr_q      <= BASE_ADDR;
      we_q        <= 1'b0;
      cpu_reset_q <= 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q      <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      len_lo_q    <= len_lo_d;
      len_q       <= len_d;
      lo_byte_q   <= lo_byte_d;
      count_q     <= count_d;
      instr_q     <= instr_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      // Lags done by one edge so the final write lands before the CPU fetches.
      cpu_reset_q <= (state_q != S_DONE);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign bus.byte_ready_o           = byte_ready;
  assign bus.program_mem_write_en_o = we_q;
  assign bus.instruction_o          = instr_q;
  assign bus.instruction_addr_o     = addr_q;
  assign bus.cpu_reset_o            = cpu_reset_q;
  assign bus.done_o                 = (state_q == S_DONE);
  assign bus.error_o                = (state_q == S_ERROR);
  assign bus.loaded_count_o         = count_q;

endmodule
